// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: executes one RTC register read or write on the multiplexed
// A/D bus as an address phase followed by a data phase, then pulses rsp_valid.
// All bus-facing outputs come straight from flops so they never glitch.
module rtc_bus_ctrl #(
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2,
  parameter int T_GAP    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_sel,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam int TMAX = (T_STROBE > T_HOLD) ?
                        ((T_STROBE > T_GAP) ? T_STROBE : T_GAP) :
                        ((T_HOLD   > T_GAP) ? T_HOLD   : T_GAP);
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AHOLD, S_GAP, S_DATA, S_DHOLD, S_DONE
  } state_t;

  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  cmd_t          cmd_q, cmd_nxt;
  logic          accept, last;

  // next-cycle values of the registered outputs
  logic       cs_d, rd_d, wr_d, sel_d, oe_d, rsp_d;
  logic [7:0] aout_d;

  assign cmd_ready = (state == S_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != S_IDLE);
  assign last      = (cnt == '0);
  // the accept edge already drives ADDR, so use the live command there
  assign cmd_nxt   = accept ? cmd_t'{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata} : cmd_q;

  // state sequencing with a single down-counter reloaded on every state entry
  always_comb begin
    nxt     = state;
    cnt_nxt = last ? '0 : cnt - CW'(1);
    case (state)
      S_IDLE:  begin
        cnt_nxt = '0;
        if (accept) begin nxt = S_ADDR;  cnt_nxt = CW'(T_STROBE - 1); end
      end
      S_ADDR:  if (last) begin nxt = S_AHOLD; cnt_nxt = CW'(T_HOLD - 1);   end
      S_AHOLD: if (last) begin nxt = S_GAP;   cnt_nxt = CW'(T_GAP - 1);    end
      S_GAP:   if (last) begin nxt = S_DATA;  cnt_nxt = CW'(T_STROBE - 1); end
      S_DATA:  if (last) begin nxt = S_DHOLD; cnt_nxt = CW'(T_HOLD - 1);   end
      S_DHOLD: if (last) begin nxt = S_DONE;  cnt_nxt = '0;                end
      S_DONE:  begin nxt = S_IDLE; cnt_nxt = '0; end
      default: begin nxt = S_IDLE; cnt_nxt = '0; end
    endcase
  end

  // bus output decode for the state being entered; ad_sel flips only in
  // GAP/DONE->IDLE where cs_n is high on both sides of the edge
  always_comb begin
    cs_d   = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    oe_d   = 1'b0;
    rsp_d  = 1'b0;
    sel_d  = ad_sel;
    aout_d = ad_out;
    case (nxt)
      S_IDLE:  sel_d = 1'b0;
      S_ADDR:  begin cs_d = 1'b0; wr_d = 1'b0; sel_d = 1'b0; oe_d = 1'b1; aout_d = cmd_nxt.addr; end
      S_AHOLD: begin sel_d = 1'b0; oe_d = 1'b1; aout_d = cmd_nxt.addr; end
      S_GAP:   sel_d = 1'b1;
      S_DATA:  begin
        cs_d  = 1'b0;
        sel_d = 1'b1;
        if (cmd_nxt.rw) rd_d = 1'b0;
        else begin wr_d = 1'b0; oe_d = 1'b1; aout_d = cmd_nxt.wdata; end
      end
      S_DHOLD: begin
        sel_d = 1'b1;
        if (!cmd_nxt.rw) begin oe_d = 1'b1; aout_d = cmd_nxt.wdata; end
      end
      S_DONE:  rsp_d = 1'b1;
      default: ;
    endcase
  end

  // state, counter, captured command and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cmd_q     <= '0;
      cs_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      ad_sel    <= 1'b0;
      ad_out    <= 8'h00;
      ad_oe     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      cmd_q     <= cmd_nxt;
      cs_n      <= cs_d;
      rd_n      <= rd_d;
      wr_n      <= wr_d;
      ad_sel    <= sel_d;
      ad_out    <= aout_d;
      ad_oe     <= oe_d;
      rsp_valid <= rsp_d;
      // read data is sampled at the edge closing the last strobed DATA cycle
      if (state == S_DATA && last && cmd_q.rw) rsp_rdata <= ad_in;
    end
  end

endmodule
